// File: rtl/network_sink_packer_pkg.sv
// -----------------------------------------------------------------------------
// sink_config
// Shared configuration for the network sink packer.
//   NET_NUM_OUT        : width of the network output vector
//   SNK_WIDTH_DEFAULT  : default width of one output beat
//   NUM_BEATS          : beats per vector for the default configuration
//   BEAT_CNT_W         : beat-counter width for the default configuration
// The helper functions let a parameterised instance derive its own beat
// count and counter width from its actual SNK_WIDTH / NET_NUM_OUT.
// -----------------------------------------------------------------------------
package sink_config;

    localparam int NET_NUM_OUT       = 10;
    localparam int SNK_WIDTH_DEFAULT = 8;

    // ceil(net_bits / beat_bits)
    function automatic int calc_num_beats(input int net_bits, input int beat_bits);
        return (net_bits + beat_bits - 1) / beat_bits;
    endfunction

    // A single-beat configuration still gets a 1-bit counter (held at 0).
    function automatic int calc_cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    localparam int NUM_BEATS  = calc_num_beats(NET_NUM_OUT, SNK_WIDTH_DEFAULT);
    localparam int BEAT_CNT_W = calc_cnt_width(NUM_BEATS);

endpackage

// File: rtl/network_sink_packer_fifo.sv
// -----------------------------------------------------------------------------
// sink_vector_fifo
// Small vector FIFO used by network_sink_packer when SNK_FIFO_EN is defined.
//   clk, arst  : clock, asynchronous active-high reset
//   push       : write push_data (ignored while ready is low)
//   push_data  : vector to store
//   pop        : drop the head entry (ignored while empty)
//   head       : current head entry (valid while not_empty)
//   not_empty  : at least one entry stored
//   ready      : registered (count < DEPTH); a pop in the same cycle does
//                not make room for a push in that cycle
// -----------------------------------------------------------------------------
module sink_vector_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             ready
);
    import sink_config::*;

    localparam int PW    = calc_cnt_width(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    assign do_push   = push && ready_q;
    assign do_pop    = pop && (count_q != '0);
    assign head      = mem[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign ready     = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage carries no reset; count/pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/network_sink_packer.sv
// -----------------------------------------------------------------------------
// network_sink_packer
// Accepts NET_NUM_OUT-bit network vectors and serialises each one into
// ceil(NET_NUM_OUT/SNK_WIDTH) beats. Within a beat the lowest vector bit
// lands in the MSB; the final beat is zero padded.
//   clk        : clock
//   arst       : asynchronous active-high reset
//   net_valid  : vector on net_out is valid
//   net_ready  : packer accepts a vector this cycle
//   net_out    : network output vector
//   snk_ready  : downstream accepts the current beat
//   snk_valid  : beat on snk is valid
//   snk        : packed beat
//   snk_last   : current beat is the last of its vector
// Build option: define SNK_FIFO_EN to buffer FIFO_DEPTH vectors in
// sink_vector_fifo; otherwise a single holding register is used.
// -----------------------------------------------------------------------------
module network_sink_packer #(
    parameter int NET_NUM_OUT = sink_config::NET_NUM_OUT,
    parameter int SNK_WIDTH   = sink_config::SNK_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   net_valid,
    output logic                   net_ready,
    input  logic [NET_NUM_OUT-1:0] net_out,
    input  logic                   snk_ready,
    output logic                   snk_valid,
    output logic [SNK_WIDTH-1:0]   snk,
    output logic                   snk_last
);
    import sink_config::*;

    localparam int NB    = calc_num_beats(NET_NUM_OUT, SNK_WIDTH);
    localparam int CW    = calc_cnt_width(NB);
    localparam int PAD_W = NB * SNK_WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

    // Configuration sanity check at elaboration.
    if (SNK_WIDTH < 1 || SNK_WIDTH > NET_NUM_OUT || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_config
        $error("network_sink_packer: illegal SNK_WIDTH or FIFO_DEPTH");
    end

    logic [NET_NUM_OUT-1:0] vec_cur;     // vector currently being serialised
    logic [PAD_W-1:0]       vec_pad;
    logic [SNK_WIDTH-1:0]   beat_raw;
    logic [SNK_WIDTH-1:0]   beat_rev;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   beat_xfer, last_beat, last_xfer;

    // ---------------- beat selection ----------------
    if (PAD_W == NET_NUM_OUT) begin : g_no_pad
        assign vec_pad = vec_cur;
    end else begin : g_pad
        assign vec_pad = {{(PAD_W - NET_NUM_OUT){1'b0}}, vec_cur};
    end

    assign beat_raw = vec_pad[int'(cnt_q) * SNK_WIDTH +: SNK_WIDTH];

    // Vector bit k*W+j goes to beat bit W-1-j.
    for (genvar gi = 0; gi < SNK_WIDTH; gi++) begin : g_rev
        assign beat_rev[SNK_WIDTH - 1 - gi] = beat_raw[gi];
    end

    // Gate with valid so snk reads zero while idle or in reset.
    assign snk      = snk_valid ? beat_rev : '0;
    assign snk_last = snk_valid && last_beat;

    // ---------------- beat counter ----------------
    always_comb begin
        beat_xfer = snk_valid && snk_ready;
        last_beat = (cnt_q == LAST_CNT);
        last_xfer = beat_xfer && last_beat;
        cnt_d     = cnt_q;
        if (beat_xfer) cnt_d = last_beat ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

`ifdef SNK_FIFO_EN
    // ---------------- FIFO-buffered storage ----------------
    logic                   fifo_ready;
    logic                   fifo_not_empty;
    logic [NET_NUM_OUT-1:0] fifo_head;

    sink_vector_fifo #(
        .WIDTH (NET_NUM_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (net_valid && fifo_ready),
        .push_data (net_out),
        .pop       (last_xfer),
        .head      (fifo_head),
        .not_empty (fifo_not_empty),
        .ready     (fifo_ready)
    );

    assign net_ready = fifo_ready;
    assign snk_valid = fifo_not_empty;
    assign vec_cur   = fifo_head;
`else
    // ---------------- single holding register ----------------
    logic [NET_NUM_OUT-1:0] vec_q, vec_d;
    logic                   full_q, full_d;
    logic                   rdy_en_q, rdy_en_d;   // low until first edge after reset
    logic                   accept;

    // Refill in the same cycle the last beat leaves: no bubble between vectors.
    assign net_ready = rdy_en_q && (!full_q || last_xfer);
    assign accept    = net_valid && net_ready;
    assign snk_valid = full_q;
    assign vec_cur   = vec_q;

    always_comb begin
        vec_d    = vec_q;
        full_d   = full_q;
        rdy_en_d = 1'b1;
        if (accept) begin
            vec_d  = net_out;
            full_d = 1'b1;
        end else if (last_xfer) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vec_q    <= '0;
            full_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            full_q   <= full_d;
            rdy_en_q <= rdy_en_d;
        end
    end
`endif

endmodule

// File: doc/network_sink_packer.md
NETWORK_SINK_PACKER -- requirements
Module: network_sink_packer

Interface
REQ-001 SHALL have parameter SNK_WIDTH, default 8: output beat width in bits, 1 to NET_NUM_OUT.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: vector FIFO entries, power of two, at least 2; used only with SNK_FIFO_EN.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port net_valid  input  1  network output vector valid.
REQ-006 SHALL have port net_ready  output  1  packer can accept a vector.
REQ-007 SHALL have port net_out  input  NET_NUM_OUT  network output vector.
REQ-008 SHALL have port snk_ready  input  1  downstream accepts beat.
REQ-009 SHALL have port snk_valid  output  1  beat on snk is valid.
REQ-010 SHALL have port snk  output  SNK_WIDTH  packed output beat.
REQ-011 SHALL have port snk_last  output  1  current beat is the final beat of its vector.

Function
REQ-012 SHALL define NUM_BEATS = ceil(NET_NUM_OUT / SNK_WIDTH); each accepted vector SHALL emit exactly NUM_BEATS beats, in order.
REQ-013 Beat k, bit SNK_WIDTH-1-j SHALL equal net_out[k*SNK_WIDTH+j] when that index is below NET_NUM_OUT, else 0 (zero padding in the final beat only).
REQ-014 Vector transfer SHALL occur on a clk edge with net_valid and net_ready high; beat transfer SHALL occur on a clk edge with snk_valid and snk_ready high.
REQ-015 Accepted vector SHALL be registered; its first beat SHALL be valid the cycle after acceptance when the output is idle (latency 1).
REQ-016 While snk_valid is high and snk_ready is low, snk, snk_last and snk_valid SHALL hold stable.
REQ-017 A beat counter (0..NUM_BEATS-1) SHALL advance on each beat transfer and wrap to 0 after the last beat; snk_last SHALL be high when counter equals NUM_BEATS-1 and snk_valid is high.
REQ-018 When NUM_BEATS = 1, snk_last SHALL be high whenever snk_valid is high.
REQ-019 With continuous net_valid and snk_ready, output SHALL sustain one beat per cycle with no bubble between vectors.
REQ-020 snk_valid SHALL be low when no vector is held or buffered.

Reset
REQ-021 arst high SHALL immediately force snk_valid=0, snk=0, snk_last=0, net_ready=0, beat counter=0, FIFO empty; partially sent vectors SHALL be discarded.
REQ-022 net_ready SHALL rise on the first clk edge after arst deasserts.

Configuration
REQ-023 Macro SNK_FIFO_EN defined: vectors SHALL be stored in a FIFO of FIFO_DEPTH entries; head entry is serialised and popped on its last beat transfer; net_ready SHALL equal (count < FIFO_DEPTH), registered, with no same-cycle pop bypass; simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Macro SNK_FIFO_EN undefined: a single holding register SHALL be used; net_ready SHALL be high when empty or when the last beat transfers this cycle, allowing back-to-back vectors.

Structure
REQ-025 NUM_BEATS, SNK_WIDTH default and beat-counter width SHALL live in package sink_config alongside NET_NUM_OUT import.
REQ-026 The FIFO SHALL be a sub-module sink_vector_fifo (width NET_NUM_OUT, depth FIFO_DEPTH), instantiated only under SNK_FIFO_EN.

Verification
REQ-027 NET_NUM_OUT=10, SNK_WIDTH=4, net_out=10'h301, snk_ready=1 -> beats 4'b1000, 4'b0000, 4'b1100; snk_last only on third.
REQ-028 Same config, snk_ready low 5 cycles during beat 1 -> snk holds 4'b0000, snk_valid stays 1, then sequence completes unchanged.
REQ-029 Two vectors 10'h3FF then 10'h001 back-to-back, snk_ready=1 -> 6 consecutive beats 1111,1111,1100,1000,0000,0000, no idle cycle.
REQ-030 SNK_FIFO_EN, FIFO_DEPTH=4, snk_ready=0, push 5 vectors -> 4 accepted, net_ready low after 4th; on snk_ready=1 drain in push order, net_ready rises after first pop.
REQ-031 arst pulsed during beat 1 of a vector -> snk_valid 0 immediately, next vector starts at beat 0, discarded vector never resumes.
REQ-032 SNK_WIDTH=NET_NUM_OUT=8, net_out=8'h01 -> single beat 8'h80 with snk_last=1.
